gray_alu_pipe: RTL

- Parametrised, pipelined successor to the 4-bit Gray-coded ALU core.
- Takes two WIDTH-bit Gray-coded signed (two's complement after decode) operands and a 2-bit op, and returns a Gray-coded result with Zero/Overflow flags.
- Valid/ready handshake with full backpressure; a sticky overflow flag and a saturating result counter.
- Sits between the Gray-coded operand source (counters/encoders) and downstream Gray-coded consumers.

---
 rtl/gray_alu_pkg.sv | 28 ++
 rtl/gray_alu_pipe_calc.sv | 57 +++++
 rtl/gray_alu_pipe.sv | 111 +++++++++++
 3 files changed

// File: rtl/gray_alu_pkg.sv
// Shared types and Gray-code helpers for the pipelined Gray-coded ALU.
// The helpers work on a wide vector, so callers zero-extend their operand in and cast the result down.
package gray_alu_pkg;

  localparam int GW = 64;

  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_SUB     = 2'b01,
    OP_ABSDIFF = 2'b10,
    OP_AVG     = 2'b11
  } op_e;

  // Zero bits above the caller's width leave the prefix-XOR unaffected.
  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b[GW-1] = g[GW-1];
    for (int i = GW - 2; i >= 0; i--) begin
      b[i] = g[i] ^ b[i+1];
    end
    return b;
  endfunction

  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_alu_pipe_calc.sv
// Combinational signed ALU core. It computes at WIDTH+1 bits so that carries and overflow stay visible.
module gray_alu_calc
  import gray_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             overflow
);

  logic [WIDTH:0] w_sa;
  logic [WIDTH:0] w_sb;
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;
  logic [WIDTH:0] w_absd;

  assign w_sa   = {a[WIDTH-1], a};
  assign w_sb   = {b[WIDTH-1], b};
  assign w_sum  = w_sa + w_sb;
  assign w_diff = w_sa - w_sb;
  assign w_absd = w_diff[WIDTH] ? (~w_diff + 1'b1) : w_diff;

  always_comb begin
    r        = w_sum[WIDTH-1:0];
    overflow = w_sum[WIDTH] ^ w_sum[WIDTH-1];
    case (op)
      OP_ADD: begin
        r        = w_sum[WIDTH-1:0];
        overflow = w_sum[WIDTH] ^ w_sum[WIDTH-1];
      end
      OP_SUB: begin
        r        = w_diff[WIDTH-1:0];
        overflow = w_diff[WIDTH] ^ w_diff[WIDTH-1];
      end
      OP_ABSDIFF: begin
        // |d| is unsigned; anything at or above 2^(WIDTH-1) does not fit the signed result.
        r        = w_absd[WIDTH-1:0];
        overflow = w_absd[WIDTH] | w_absd[WIDTH-1];
      end
      OP_AVG: begin
        r        = w_sum[WIDTH:1];
        overflow = 1'b0;
      end
      default: begin
        r        = w_sum[WIDTH-1:0];
        overflow = 1'b0;
      end
    endcase
  end

  assign zero = (r == '0);

endmodule

// File: rtl/gray_alu_pipe.sv
// Two-stage Gray-coded ALU with valid/ready backpressure, a sticky overflow flag and a delivery counter.
// Stage 1 holds the decoded operands and stage 2 holds the encoded result that drives the outputs.
module gray_alu_pipe
  import gray_alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] g_a,
  input  logic [WIDTH-1:0] g_b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r_gray,
  output logic             zero,
  output logic             overflow,
  output logic             ovf_sticky,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] result_cnt
);

  logic             r_v1;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  op_e              r_op;
  logic             r_v2;
  logic [WIDTH-1:0] r_res_gray;
  logic             r_zero;
  logic             r_ovf;
  logic             r_sticky;
  logic [CNT_W-1:0] r_cnt;

  logic             w_s1_load;
  logic             w_s2_load;
  logic             w_deliver;
  logic [WIDTH-1:0] w_a_bin;
  logic [WIDTH-1:0] w_b_bin;
  logic [WIDTH-1:0] w_r;
  logic             w_zero;
  logic             w_ovf;

  assign w_s2_load = !r_v2 || out_ready;
  assign w_s1_load = !r_v1 || w_s2_load;
  assign w_deliver = r_v2 && out_ready;

  assign w_a_bin = WIDTH'(gray2bin(GW'(g_a)));
  assign w_b_bin = WIDTH'(gray2bin(GW'(g_b)));

  gray_alu_calc #(.WIDTH(WIDTH)) u_calc (
    .a        (r_a),
    .b        (r_b),
    .op       (r_op),
    .r        (w_r),
    .zero     (w_zero),
    .overflow (w_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1       <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= OP_ADD;
      r_v2       <= 1'b0;
      r_res_gray <= '0;
      r_zero     <= 1'b0;
      r_ovf      <= 1'b0;
      r_sticky   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_s1_load) begin
        r_v1 <= in_valid;
        if (in_valid) begin
          r_a  <= w_a_bin;
          r_b  <= w_b_bin;
          r_op <= op_e'(op);
        end
      end
      // Stage 2 only refreshes its data when a real beat moves in, so a stalled result stays put.
      if (w_s2_load) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_res_gray <= WIDTH'(bin2gray(GW'(w_r)));
          r_zero     <= w_zero;
          r_ovf      <= w_ovf;
        end
      end
      if (w_deliver && r_ovf) begin
        r_sticky <= 1'b1;
      end else if (clr_sticky) begin
        r_sticky <= 1'b0;
      end
      if (w_deliver && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready   = !r_v1 || !r_v2 || out_ready;
  assign out_valid  = r_v2;
  assign r_gray     = r_res_gray;
  assign zero       = r_zero;
  assign overflow   = r_ovf;
  assign ovf_sticky = r_sticky;
  assign result_cnt = r_cnt;

endmodule
